// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owner, timeout fill word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Requester that owns the transaction in flight for a given BUSY state.
  function automatic owner_e owner_of(input arb_state_e s);
    return (s == BUSY_IF) ? OWN_IF : OWN_DM;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data ports: data-port priority with a
// saturating starvation counter that forces a fetch grant.
module arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_dm
);

  localparam int unsigned     CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             if_forced;

  always_comb begin
    if_forced    = (starve_cnt_q == CNT_MAX);
    grant_if     = grant_en & if_req & (~dm_req | if_forced);
    grant_dm     = grant_en & dm_req & ~grant_if;
    starve_cnt_d = starve_cnt_q;
    // Count only data grants that actually made fetch wait.
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_dm && if_req && !if_forced) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and the MEM-stage data port.
// Optional watchdog abort of hung transactions under `ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              grant_en, grant_if, grant_dm;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            arb_err_q, arb_err_d;
`endif

  // No new grant in a completion cycle, so a finishing requester can drop its request.
  assign grant_en = (state_q == IDLE) & ~if_valid_q & ~dm_valid_q;

  arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_en(grant_en),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    done        = 1'b0;
    rsp_data    = mem_rdata;
`ifdef ARB_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    arb_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d    = '0;
`endif
        end else if (grant_if) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d   = '0;
`endif
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          done = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (wd_cnt_q == WD_LAST) begin
          done      = 1'b1;
          rsp_data  = DATA_W'(DEADBEEF);
          arb_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion: release memory and hand the response to the owning port.
    if (done) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (owner_of(state_q) == OWN_IF) begin
        if_valid_d = 1'b1;
        if_rdata_d = rsp_data;
      end else begin
        dm_valid_d = 1'b1;
        if (!mem_we_q) dm_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_q    <= '0;
      arb_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      arb_err_q   <= arb_err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign arb_err   = arb_err_q;
`else
  assign arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-programmable memory responder plus a
// completion scoreboard; exercises the timeout path when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clock, reset;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, arb_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(4)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
  );

  typedef struct {
    bit          we;
    logic [31:0] rdata;
  } dm_exp_t;

  logic [31:0] exp_if_q[$];
  dm_exp_t     exp_dm_q[$];
  logic        grant_log[$];   // 1 = fetch grant; fetch addresses are below 0x100
  int          checks, errors, arb_err_seen, mem_lat;
  logic [31:0] model_dm_rdata;
  logic        mem_req_prev;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h8C22_0044;
  endfunction

  task automatic push_dm(input bit we, input logic [31:0] rdata);
    dm_exp_t r;
    r.we = we;
    r.rdata = rdata;
    exp_dm_q.push_back(r);
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: mem_ready on the mem_lat-th cycle of mem_req (0 = never answers).
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (mem_req === 1'b1 && mem_lat != 0) begin
        cnt++;
        if (cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = data_of(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  initial begin : monitor
    logic [31:0] e;
    dm_exp_t     r;
    mem_req_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1 && mem_req_prev !== 1'b1) grant_log.push_back(mem_addr < 32'h100);
      mem_req_prev = mem_req;
      if (arb_err === 1'b1) arb_err_seen++;
      if (if_valid === 1'b1) begin
        checks++;
        if (exp_if_q.size() == 0) begin
          errors++;
          $display("FAIL if_unexpected: if_valid=1 got if_rdata=%h, required no completion", if_rdata);
        end else begin
          e = exp_if_q.pop_front();
          if (if_rdata !== e) begin
            errors++;
            $display("FAIL if_rdata: got %h required %h", if_rdata, e);
          end
        end
        checks++;
        if (if_stall !== 1'b0) begin
          errors++;
          $display("FAIL if_stall_at_valid: got %b required 0", if_stall);
        end
      end
      if (dm_valid === 1'b1) begin
        checks++;
        if (exp_dm_q.size() == 0) begin
          errors++;
          $display("FAIL dm_unexpected: dm_valid=1 got dm_rdata=%h, required no completion", dm_rdata);
        end else begin
          r = exp_dm_q.pop_front();
          if (dm_rdata !== r.rdata) begin
            errors++;
            $display("FAIL dm_rdata(we=%0d): got %h required %h", r.we, dm_rdata, r.rdata);
          end
        end
        checks++;
        if (dm_stall !== 1'b0) begin
          errors++;
          $display("FAIL dm_stall_at_valid: got %b required 0", dm_stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({mem_req, mem_we, if_valid, dm_valid, if_stall, dm_stall, arb_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {mem_req, mem_we, if_valid, dm_valid, if_stall, dm_stall, arb_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h required all zero", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_if_only();
    mem_lat = 1;
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 32'h40;
    exp_if_q.push_back(32'h8C22_0004);
    @(negedge clock);
    checks++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL if_req_cycle: got stall=%b mem_req=%b required 1 0", if_stall, mem_req);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL if_mem_issue: got req=%b addr=%h we=%b valid=%b required 1 00000040 0 0",
               mem_req, mem_addr, mem_we, if_valid);
    end
    @(negedge clock);
    checks++;
    if (if_valid !== 1'b1) begin
      errors++;
      $display("FAIL if_latency: got if_valid=%b at N+2 required 1", if_valid);
    end
    @(posedge clock); #1 if_req = 1'b0;
    @(negedge clock);
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h8C22_0004) begin
      errors++;
      $display("FAIL if_after: got valid=%b req=%b rdata=%h required 0 0 8c220004", if_valid, mem_req, if_rdata);
    end
  endtask

  task automatic test_collision();
    int if_done = 0;
    int dm_done = 0;
    int base;
    bit stall_ok = 1'b1;
    bit got_if, got_dm;
    mem_lat = 1;
    base = grant_log.size();
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 32'h48;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    push_dm(1'b0, data_of(32'h100));
    model_dm_rdata = data_of(32'h100);
    exp_if_q.push_back(data_of(32'h48));
    for (int cyc = 1; cyc <= 20 && if_done == 0; cyc++) begin
      @(negedge clock);
      got_if = (if_valid === 1'b1);
      got_dm = (dm_valid === 1'b1);
      if (got_dm) dm_done = cyc;
      if (got_if) if_done = cyc;
      else if (if_stall !== 1'b1) stall_ok = 1'b0;
      if (got_if || got_dm) begin
        @(posedge clock); #1;
        if (got_dm) dm_req = 1'b0;
        if (got_if) if_req = 1'b0;
      end
    end
    checks++;
    if (dm_done != 3 || if_done != 6) begin
      errors++;
      $display("FAIL collision_timing: got dm_valid@%0d if_valid@%0d required 3 and 6", dm_done, if_done);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL collision_if_stall: got a low if_stall while waiting, required high");
    end
    checks++;
    if (grant_log.size() != base + 2 || grant_log[base] !== 1'b0 || grant_log[base+1] !== 1'b1) begin
      errors++;
      $display("FAIL collision_order: got %0d grants, required DM then IF", grant_log.size() - base);
    end
  endtask

  task automatic test_store();
    int we_cyc = 0;
    int valid_cnt = 0;
    int valid_at = 0;
    mem_lat = 3;
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
    push_dm(1'b1, model_dm_rdata);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h200 && mem_wdata === 32'h1234_5678)
        we_cyc++;
      if (dm_valid === 1'b1) begin
        valid_cnt++;
        if (valid_at == 0) valid_at = cyc;
        @(posedge clock); #1 dm_req = 1'b0; dm_we = 1'b0;
      end
    end
    checks++;
    if (we_cyc != 3) begin
      errors++;
      $display("FAIL store_mem_we_hold: got %0d cycles required 3", we_cyc);
    end
    checks++;
    if (valid_cnt != 1 || valid_at != 5) begin
      errors++;
      $display("FAIL store_valid: got %0d pulses first@%0d required 1 at 5", valid_cnt, valid_at);
    end
  endtask

  task automatic test_starvation();
    logic exp_seq[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   done_cnt = 0;
    int   base;
    bit   fin = 1'b0;
    logic got;
    mem_lat = 1;
    base = grant_log.size();
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 32'h4C;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int i = 0; i < 8; i++) push_dm(1'b0, data_of(32'h300));
    for (int i = 0; i < 2; i++) exp_if_q.push_back(data_of(32'h4C));
    model_dm_rdata = data_of(32'h300);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clock);
      if (if_valid === 1'b1) done_cnt++;
      if (dm_valid === 1'b1) done_cnt++;
      if (done_cnt == 10) begin
        @(posedge clock); #1;
        if_req = 1'b0; dm_req = 1'b0;
        fin = 1'b1;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL starve_timeout: got %0d completions required 10", done_cnt);
      if_req = 1'b0; dm_req = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      got = 1'bx;
      if (grant_log.size() > base + i) got = grant_log[base+i];
      checks++;
      if (got !== exp_seq[i]) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got is_if=%b required %b", i, got, exp_seq[i]);
      end
    end
    checks++;
    if (grant_log.size() != base + 10) begin
      errors++;
      $display("FAIL starve_grant_count: got %0d required 10", grant_log.size() - base);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit quiet = 1'b1;
    int valid_at = 0;
    mem_lat = 0;
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
    repeat (3) @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin
      errors++;
      $display("FAIL rst_busy_setup: got req=%b addr=%h required 1 00000180", mem_req, mem_addr);
    end
    @(posedge clock); #1;
    reset = 1'b1; dm_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mem_lat = 1;
    model_dm_rdata = '0;
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0 || dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_after: got req=%b dv=%b iv=%b rdata=%h required 0 0 0 0",
               mem_req, dm_valid, if_valid, dm_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (mem_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL rst_stale: got activity after reset, required idle");
    end
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    push_dm(1'b0, data_of(32'h100));
    model_dm_rdata = data_of(32'h100);
    for (int cyc = 1; cyc <= 10 && valid_at == 0; cyc++) begin
      @(negedge clock);
      if (dm_valid === 1'b1) begin
        valid_at = cyc;
        @(posedge clock); #1 dm_req = 1'b0;
      end
    end
    checks++;
    if (valid_at != 3) begin
      errors++;
      $display("FAIL rst_recover: got dm_valid@%0d required 3", valid_at);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int   valid_at = 0;
    logic err_at_valid = 1'b0;
    mem_lat = 0;
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1C0;
    push_dm(1'b0, 32'hDEAD_BEEF);
    model_dm_rdata = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 20 && valid_at == 0; cyc++) begin
      @(negedge clock);
      if (dm_valid === 1'b1) begin
        valid_at = cyc;
        err_at_valid = arb_err;
        @(posedge clock); #1 dm_req = 1'b0;
      end
    end
    mem_lat = 1;
    checks++;
    if (valid_at != 10 || err_at_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: got dm_valid@%0d arb_err=%b required 10 and 1", valid_at, err_at_valid);
    end
  endtask
`endif

  task automatic test_final();
    int exp_err;
`ifdef ARB_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    repeat (3) @(negedge clock);
    checks++;
    if (exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d if / %0d dm outstanding required 0 0",
               exp_if_q.size(), exp_dm_q.size());
    end
    checks++;
    if (arb_err_seen != exp_err) begin
      errors++;
      $display("FAIL arb_err_count: got %0d pulses required %0d", arb_err_seen, exp_err);
    end
  endtask

  initial begin
    checks = 0; errors = 0; arb_err_seen = 0; mem_lat = 1;
    model_dm_rdata = '0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_if_only();
    test_collision();
    test_store();
    test_starvation();
    test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
